// File: rtl/vga_timing_gen.sv
// Raster counters, sync decode and registered pixel output stage.
// Counters feed image logic; colour/sync reach the pins one clock later.
module vga_timing_gen #(
  parameter int   H_VISIBLE = 800,
  parameter int   H_FRONT   = 40,
  parameter int   H_SYNC    = 128,
  parameter int   H_BACK    = 88,
  parameter int   V_VISIBLE = 600,
  parameter int   V_FRONT   = 1,
  parameter int   V_SYNC    = 4,
  parameter int   V_BACK    = 23,
  parameter logic SYNC_POL  = 1'b1
) (
  input  logic        CLK40MHZ,
  input  logic        resetn,
  input  logic [11:0] pixel_data,
  output logic [11:0] Hindex,
  output logic [11:0] Vindex,
  output logic        canvas_valid,
  output logic        frame_start,
  output logic        vblank_start,
  output logic [3:0]  vgaRed,
  output logic [3:0]  vgaGreen,
  output logic [3:0]  vgaBlue,
  output logic        Hsync,
  output logic        Vsync
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_VIS  = 12'(H_VISIBLE);
  localparam logic [11:0] V_VIS  = 12'(V_VISIBLE);
  localparam logic [11:0] V_VEND = 12'(V_VISIBLE - 1);
  localparam logic [11:0] HS_LO  = 12'(H_VISIBLE + H_FRONT);
  localparam logic [11:0] HS_HI  = 12'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [11:0] VS_LO  = 12'(V_VISIBLE + V_FRONT);
  localparam logic [11:0] VS_HI  = 12'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [11:0] h;
  logic [11:0] v;
  logic        h_last;
  logic        v_last;
  logic        hsync_raw;
  logic        vsync_raw;

  assign h_last = (h == H_LAST);
  assign v_last = (v == V_LAST);

  always_ff @(posedge CLK40MHZ or negedge resetn) begin
    if (!resetn) begin
      h <= '0;
      v <= '0;
    end else begin
      h <= h_last ? '0 : h + 12'd1;
      if (h_last) begin
        v <= v_last ? '0 : v + 12'd1;
      end
    end
  end

  assign Hindex       = h;
  assign Vindex       = v;
  assign canvas_valid = (h < H_VIS) && (v < V_VIS);

  always_comb begin
    hsync_raw = !SYNC_POL;
    vsync_raw = !SYNC_POL;
    if (h >= HS_LO && h <= HS_HI) hsync_raw = SYNC_POL;
    if (v >= VS_LO && v <= VS_HI) vsync_raw = SYNC_POL;
  end

  // Pixel sampled on the edge that moves the counters past it
  always_ff @(posedge CLK40MHZ or negedge resetn) begin
    if (!resetn) begin
      vgaRed       <= '0;
      vgaGreen     <= '0;
      vgaBlue      <= '0;
      Hsync        <= !SYNC_POL;
      Vsync        <= !SYNC_POL;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      vgaRed       <= canvas_valid ? pixel_data[11:8] : 4'h0;
      vgaGreen     <= canvas_valid ? pixel_data[7:4]  : 4'h0;
      vgaBlue      <= canvas_valid ? pixel_data[3:0]  : 4'h0;
      Hsync        <= hsync_raw;
      Vsync        <= vsync_raw;
      frame_start  <= h_last && v_last;
      vblank_start <= h_last && (v == V_VEND);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a shrunk raster for whole frames plus
// a default-sized instance for the first lines of real timing.
module tb_vga_timing_gen;

  localparam int HV = 16;
  localparam int HF = 3;
  localparam int HS = 5;
  localparam int HB = 4;
  localparam int VV = 10;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;

  localparam int DHT = 1056;
  localparam int DVT = 628;
  localparam int DFT = DHT * DVT;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [11:0] pixel_data = '0;

  logic [11:0] s_h, s_v, d_h, d_v;
  logic        s_cv, s_fs, s_vb, s_hs, s_vs;
  logic        d_cv, d_fs, d_vb, d_hs, d_vs;
  logic [3:0]  s_r, s_g, s_b, d_r, d_g, d_b;

  int          tests = 0;
  int          fails = 0;
  int          n = 0;
  int          mode = 0;
  int          cnt = 0;
  logic [11:0] prev_pix = '0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(1'b1)
  ) dut (
    .CLK40MHZ(clk), .resetn(resetn), .pixel_data(pixel_data),
    .Hindex(s_h), .Vindex(s_v), .canvas_valid(s_cv),
    .frame_start(s_fs), .vblank_start(s_vb),
    .vgaRed(s_r), .vgaGreen(s_g), .vgaBlue(s_b),
    .Hsync(s_hs), .Vsync(s_vs)
  );

  vga_timing_gen dut_def (
    .CLK40MHZ(clk), .resetn(resetn), .pixel_data(pixel_data),
    .Hindex(d_h), .Vindex(d_v), .canvas_valid(d_cv),
    .frame_start(d_fs), .vblank_start(d_vb),
    .vgaRed(d_r), .vgaGreen(d_g), .vgaBlue(d_b),
    .Hsync(d_hs), .Vsync(d_vs)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s n=%0d observed=%0h expected=%0h",
             tag, n, obs, exp);
    end
  endtask

  // Reference: raster position is just elapsed clocks mod line/frame
  task automatic check_one(input string pfx, input int ht, input int vt,
                           input int hv, input int vv, input int hf,
                           input int hs, input int vf, input int vs,
                           input logic [11:0] oh, input logic [11:0] ov,
                           input logic ocv, input logic ofs,
                           input logic ovb, input logic ohs,
                           input logic ovs, input logic [3:0] or_,
                           input logic [3:0] og, input logic [3:0] ob);
    int ph, pv, qh, qv, ft;
    logic qvis;
    logic [11:0] ec;
    ft = ht * vt;
    ph = n % ht;
    pv = (n / ht) % vt;
    chk({pfx, "_hindex"}, oh, ph);
    chk({pfx, "_vindex"}, ov, pv);
    chk({pfx, "_canvas"}, ocv, (ph < hv) && (pv < vv));
    if (n == 0) begin
      chk({pfx, "_rst_rgb"}, {or_, og, ob}, 12'h000);
      chk({pfx, "_rst_hsync"}, ohs, 1'b0);
      chk({pfx, "_rst_vsync"}, ovs, 1'b0);
      chk({pfx, "_rst_fs"}, ofs, 1'b0);
      chk({pfx, "_rst_vb"}, ovb, 1'b0);
    end else begin
      qh = (n - 1) % ht;
      qv = ((n - 1) / ht) % vt;
      qvis = (qh < hv) && (qv < vv);
      ec = qvis ? prev_pix : 12'h000;
      chk({pfx, "_rgb"}, {or_, og, ob}, ec);
      chk({pfx, "_hsync"}, ohs,
          (qh >= hv + hf) && (qh < hv + hf + hs));
      chk({pfx, "_vsync"}, ovs,
          (qv >= vv + vf) && (qv < vv + vf + vs));
      chk({pfx, "_frame_start"}, ofs, (n % ft) == 0);
      chk({pfx, "_vblank_start"}, ovb, (n % ft) == vv * ht);
    end
  endtask

  task automatic check_all();
    check_one("s", HT, VT, HV, VV, HF, HS, VF, VS, s_h, s_v, s_cv,
              s_fs, s_vb, s_hs, s_vs, s_r, s_g, s_b);
    check_one("d", DHT, DVT, 800, 600, 40, 128, 1, 4, d_h, d_v, d_cv,
              d_fs, d_vb, d_hs, d_vs, d_r, d_g, d_b);
  endtask

  task automatic drive();
    case (mode)
      0: pixel_data = 12'($urandom);
      1: pixel_data = 12'hFFF;
      default: pixel_data = ((n % FT) == 0) ? 12'hA5C : 12'h000;
    endcase
  endtask

  task automatic step();
    prev_pix = pixel_data;
    @(posedge clk);
    #1;
    n++;
    check_all();
    if (mode == 1 && s_r == 4'hF) cnt++;
    if (mode == 2 && {s_r, s_g, s_b} == 12'hA5C) cnt++;
    drive();
  endtask

  initial begin
    // Reset held across an edge: outputs idle, counters at origin
    #12;
    n = 0;
    check_all();
    mode = 0;
    drive();
    resetn = 1'b1;
    repeat (3 * FT) step();

    // Asynchronous reset in the middle of hsync
    while ((n % HT) != HV + HF + 2) step();
    chk("pre_rst_hsync", s_hs, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    n = 0;
    check_all();
    #1;
    mode = 1;
    drive();
    resetn = 1'b1;

    cnt = 0;
    repeat (FT) step();
    chk("white_count", cnt, HV * VV);

    mode = 2;
    cnt = 0;
    drive();
    repeat (FT) step();
    chk("a5c_count", cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
